// File: rtl/dtree_pkg.sv
// Shared types and defaults for the serial decision-tree front-end.
// Feature slot k occupies bits [k*FEAT_W +: FEAT_W] of the feature bus.
package dtree_pkg;

  localparam int DEF_NUM_FEAT = 5;
  localparam int DEF_FEAT_W   = 8;
  localparam int DEF_CLASS_W  = 5;
  localparam int DEF_TIMEOUT  = 15;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_e;

  function automatic int slot_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/dtree_feat_shiftreg.sv
// Slot-addressed feature register bank.
// One slot is written per enabled cycle; all other slots hold.
module dtree_feat_shiftreg
  import dtree_pkg::*;
#(
  parameter int NUM_FEAT = DEF_NUM_FEAT,
  parameter int FEAT_W   = DEF_FEAT_W,
  parameter int IDX_W    = $clog2(DEF_NUM_FEAT)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [IDX_W-1:0]           idx,
  input  logic [FEAT_W-1:0]          din,
  output logic [NUM_FEAT*FEAT_W-1:0] bus
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus <= '0;
    end else if (we) begin
      for (int k = 0; k < NUM_FEAT; k++) begin
        if (idx == IDX_W'(k)) begin
          bus[slot_lo(k, FEAT_W) +: FEAT_W] <= din;
        end
      end
    end
  end

endmodule

// File: rtl/dtree_serial_ctrl.sv
// Serial feature loader, classifier sequencer and result register
// for the printed decision-tree classifiers.
module dtree_serial_ctrl
  import dtree_pkg::*;
#(
  parameter int NUM_FEAT = DEF_NUM_FEAT,
  parameter int FEAT_W   = DEF_FEAT_W,
  parameter int CLASS_W  = DEF_CLASS_W,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FEAT_W-1:0]          in_data,
  input  logic                       in_last,
  output logic [NUM_FEAT*FEAT_W-1:0] feat_bus,
  input  logic [CLASS_W-1:0]         cls_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CLASS_W-1:0]         out_class,
  output logic                       err_frame,
  output logic [15:0]                frame_cnt
);

  localparam int IDX_W  = $clog2(NUM_FEAT);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_FEAT - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);

  state_e             state, state_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [IDLE_W-1:0]  idle_cnt, idle_d;
  logic               err_d;
  logic               oval_d;
  logic [CLASS_W-1:0] ocls_d;
  logic [15:0]        fcnt_d;
  logic               acc;
  logic               we;

  assign in_ready = (state == LOAD);
  assign acc      = in_valid & in_ready;

  dtree_feat_shiftreg #(
    .NUM_FEAT (NUM_FEAT),
    .FEAT_W   (FEAT_W),
    .IDX_W    (IDX_W)
  ) u_feat (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .idx   (idx),
    .din   (in_data),
    .bus   (feat_bus)
  );

  always_comb begin
    state_d = state;
    idx_d   = idx;
    idle_d  = idle_cnt;
    err_d   = 1'b0;
    oval_d  = out_valid;
    ocls_d  = out_class;
    fcnt_d  = frame_cnt;
    we      = 1'b0;
    unique case (state)
      LOAD: begin
        if (acc) begin
          we     = 1'b1;
          idle_d = '0;
          if (idx == LAST_IDX && in_last) begin
            state_d = EVAL;
            idx_d   = '0;
          end else if (idx != LAST_IDX && !in_last) begin
            idx_d = idx + IDX_W'(1);
          end else begin
            err_d = 1'b1;
            idx_d = '0;
          end
        end else if (idx != '0) begin
          // Partial frame went quiet: give up after TIMEOUT idle cycles
          if (idle_cnt == IDLE_MAX) begin
            err_d  = 1'b1;
            idx_d  = '0;
            idle_d = '0;
          end else begin
            idle_d = idle_cnt + IDLE_W'(1);
          end
        end else begin
          idle_d = '0;
        end
      end
      EVAL: begin
        ocls_d  = cls_in;
        oval_d  = 1'b1;
        fcnt_d  = frame_cnt + 16'd1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          oval_d  = 1'b0;
          state_d = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
        idx_d   = '0;
        idle_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= LOAD;
      idx       <= '0;
      idle_cnt  <= '0;
      err_frame <= 1'b0;
      out_valid <= 1'b0;
      out_class <= '0;
      frame_cnt <= '0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      idle_cnt  <= idle_d;
      err_frame <= err_d;
      out_valid <= oval_d;
      out_class <= ocls_d;
      frame_cnt <= fcnt_d;
    end
  end

endmodule

// File: tb/tb_dtree_serial_ctrl.sv
// Bench for dtree_serial_ctrl: directed scenarios plus random traffic
// checked every cycle against a frame-level queue model.
module tb_dtree_serial_ctrl;

  localparam int NF = 5;
  localparam int FW = 8;
  localparam int CW = 5;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [FW-1:0]   in_data = '0;
  logic            in_last = 1'b0;
  logic [NF*FW-1:0] feat_bus;
  logic [CW-1:0]   cls_in;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [CW-1:0]   out_class;
  logic            err_frame;
  logic [15:0]     frame_cnt;

  assign cls_in = feat_bus[39:35];

  always #5 clk = ~clk;

  dtree_serial_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .feat_bus  (feat_bus),
    .cls_in    (cls_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .err_frame (err_frame),
    .frame_cnt (frame_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit started = 0;

  // Frame-level model: beats gathered so far, completed frame, result.
  logic [7:0]  beats[$];
  logic [7:0]  m_frame[$];
  bit          m_eval = 0;
  bit          m_hold = 0;
  bit          m_err = 0;
  logic [4:0]  m_cls = '0;
  logic [15:0] m_cnt = '0;
  int          m_idle = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
  endtask

  function automatic logic [39:0] frame_bits();
    logic [39:0] v = '0;
    for (int k = 0; k < m_frame.size() && k < NF; k++) v[k*8 +: 8] = m_frame[k];
    return v;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      beats.delete();
      m_frame.delete();
      m_eval = 0;
      m_hold = 0;
      m_err  = 0;
      m_cls  = '0;
      m_cnt  = '0;
      m_idle = 0;
    end else begin
      m_err = 0;
      if (m_hold) begin
        if (out_ready) m_hold = 0;
      end else if (m_eval) begin
        m_eval = 0;
        m_hold = 1;
        m_cls  = m_frame[NF-1] >> 3;
        m_cnt  = m_cnt + 16'd1;
      end else if (in_valid) begin
        beats.push_back(in_data);
        m_idle = 0;
        if (in_last && beats.size() == NF) begin
          m_frame = beats;
          m_eval  = 1;
          beats.delete();
        end else if (in_last || beats.size() == NF) begin
          m_err = 1;
          beats.delete();
        end
      end else if (beats.size() > 0) begin
        m_idle++;
        if (m_idle == TO) begin
          m_err  = 1;
          m_idle = 0;
          beats.delete();
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready, !(m_eval || m_hold));
      chk("out_valid", out_valid, m_hold);
      chk("out_class", out_class, m_cls);
      chk("err_frame", err_frame, m_err);
      chk("frame_cnt", frame_cnt, m_cnt);
      if (m_eval || m_hold) chk("feat_bus", feat_bus, frame_bits());
    end
  end

  task automatic beat(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int k = 0; k < NF; k++) beat(f[k*8 +: 8], k == NF - 1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) chk("wait_ready_timeout", in_ready, 1'b1);
  endtask

  initial begin
    int k;
    int prev;
    bit r;

    rst_n = 1'b0;
    step();
    started = 1;
    step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 16'd0);
    chk("rst_feat_bus", feat_bus, 40'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    step();

    // 1: basic frame, result two cycles after the last beat
    out_ready = 1'b1;
    send_frame({8'hF8, 8'h40, 8'h30, 8'h20, 8'h10});
    chk("t1_eval_not_valid", out_valid, 1'b0);
    step();
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_class", out_class, 5'h1F);
    chk("t1_cnt", frame_cnt, 16'd1);
    step();
    chk("t1_released", out_valid, 1'b0);

    // 2: downstream stall
    out_ready = 1'b0;
    wait_ready();
    send_frame({8'hF8, 8'h40, 8'h30, 8'h20, 8'h10});
    step();
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold_valid", out_valid, 1'b1);
      chk("t2_hold_class", out_class, 5'h1F);
      chk("t2_hold_ready", in_ready, 1'b0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t2_ready_back", in_ready, 1'b1);
    chk("t2_cnt", frame_cnt, 16'd2);

    // 3: early in_last
    out_ready = 1'b1;
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    beat(8'h03, 1'b1);
    chk("t3_err", err_frame, 1'b1);
    step();
    chk("t3_err_pulse", err_frame, 1'b0);
    chk("t3_cnt_same", frame_cnt, 16'd2);
    send_frame({8'h48, 8'h04, 8'h03, 8'h02, 8'h01});
    step();
    chk("t3_class", out_class, 5'h09);
    chk("t3_cnt", frame_cnt, 16'd3);
    step();

    // 4: timeout after 15 idle cycles
    beat(8'hAA, 1'b0);
    beat(8'hBB, 1'b0);
    repeat (14) step();
    chk("t4_no_err_yet", err_frame, 1'b0);
    step();
    chk("t4_err", err_frame, 1'b1);
    step();
    send_frame({8'h80, 8'h11, 8'h22, 8'h33, 8'h44});
    step();
    chk("t4_class", out_class, 5'h10);
    chk("t4_slot0", feat_bus[7:0], 8'h44);
    step();

    // 5: streaming, one result every 7 cycles
    out_ready = 1'b1;
    k = 0;
    prev = -1;
    for (int c = 0; c < 40; c++) begin
      in_valid = 1'b1;
      in_data  = 8'(k * 37 + 3);
      in_last  = (k % NF == NF - 1);
      r = in_ready;
      step();
      if (r) k++;
      if (out_valid) begin
        if (prev >= 0) chk("t5_period", c - prev, 7);
        prev = c;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (20) step();

    // 6: reset during HOLD and mid-frame
    out_ready = 1'b0;
    wait_ready();
    send_frame({8'hF8, 8'h40, 8'h30, 8'h20, 8'h10});
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_valid", out_valid, 1'b0);
    chk("t6_cnt", frame_cnt, 16'd0);
    chk("t6_class", out_class, 5'd0);
    chk("t6_feat", feat_bus, 40'd0);
    chk("t6_err", err_frame, 1'b0);
    chk("t6_ready", in_ready, 1'b1);
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h03;
    step();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    chk("t6b_feat", feat_bus, 40'd0);
    chk("t6b_err", err_frame, 1'b0);
    out_ready = 1'b1;
    send_frame({8'h68, 8'h05, 8'h06, 8'h07, 8'h08});
    step();
    chk("t6b_class", out_class, 5'h0D);
    chk("t6b_cnt", frame_cnt, 16'd1);
    step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(10, 20)) step();
      end
      rst_n     = ($urandom_range(0, 299) != 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 8'($urandom);
      in_last   = (beats.size() == NF - 1);
      if ($urandom_range(0, 15) == 0) in_last = ~in_last;
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
